// File: rtl/awmc_actuator_driver.sv
// Actuator command stage for the washer controller: valve, pump, motor, buzzer, fault.
// Define AWMC_DRV_DOOR_LOCK_EN to add the door_lock output.
module awmc_actuator_driver #(
  parameter int DIR_PERIOD  = 8,
  parameter int DEAD_TIME   = 2,
  parameter int AGI_SPEED   = 6,
  parameter int RAMP_STEP   = 4,
  parameter int BUZZ_CYCLES = 6
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] stage,
  input  logic       done,
  input  logic       pause,
  output logic       valve_in,
  output logic       drain_pump,
  output logic       motor_en,
  output logic       motor_dir,
  output logic [3:0] motor_speed,
  output logic       buzzer,
`ifdef AWMC_DRV_DOOR_LOCK_EN
  output logic       door_lock,
`endif
  output logic       fault
);

  typedef enum logic [2:0] {
    M_OFF, M_CW, M_DEAD_A, M_CCW, M_DEAD_B, M_SPIN
  } mstate_t;

  localparam logic [15:0] DP = 16'(DIR_PERIOD);
  localparam logic [15:0] DT = 16'(DEAD_TIME);
  localparam logic [15:0] RS = 16'(RAMP_STEP);
  localparam logic [15:0] BC = 16'(BUZZ_CYCLES);
  localparam logic [3:0]  AS = 4'(AGI_SPEED);

  mstate_t     mstate, mstate_n;
  logic [15:0] cnt, cnt_n;
  logic [3:0]  spd, spd_n;
  logic [2:0]  prev_stage;
  logic        done_q;
  logic [15:0] buzz_cnt, buzz_n;
  logic        fault_n, rise, changed;
  logic        want_agit, want_spin, in_agit, restart;
  logic        kill, hold, rst_m, run;
  logic        valve_n, drain_n, en_n, dir_n, buzzer_n;
  logic [3:0]  speed_n;
`ifdef AWMC_DRV_DOOR_LOCK_EN
  logic [15:0] dl_cnt, dl_n;
  logic        door_n, dl_cond;
`endif

  always_comb begin
    fault_n   = fault | (stage[2] & stage[1]);
    rise      = done & ~done_q;
    buzz_n    = rise ? BC : ((buzz_cnt != 16'd0) ? buzz_cnt - 16'd1 : 16'd0);
    changed   = stage != prev_stage;
    want_agit = (stage == 3'd2) || (stage == 3'd3);
    want_spin = stage == 3'd5;
    in_agit   = mstate inside {M_CW, M_DEAD_A, M_CCW, M_DEAD_B};
    restart   = changed
              | (want_agit & ~in_agit)
              | (want_spin & (mstate != M_SPIN))
              | (~want_agit & ~want_spin & (mstate != M_OFF));
    kill  = fault_n | done;
    hold  = ~kill & pause;
    rst_m = ~kill & ~pause & restart;
    run   = ~kill & ~pause;

    mstate_n = mstate;
    cnt_n    = cnt;
    spd_n    = spd;
    unique case (1'b1)
      kill: begin
        mstate_n = M_OFF;
        cnt_n    = 16'd0;
        spd_n    = 4'd0;
      end
      hold: begin
        // agitation freezes in place; spin or an aborted mode restarts later
        if (changed || mstate == M_SPIN) begin
          mstate_n = M_OFF;
          cnt_n    = 16'd0;
          spd_n    = 4'd0;
        end
      end
      rst_m: begin
        cnt_n = 16'd1;
        spd_n = 4'd0;
        if (want_agit) begin
          mstate_n = M_CW;
        end else if (want_spin) begin
          mstate_n = M_SPIN;
          spd_n    = 4'd1;
        end else begin
          mstate_n = M_OFF;
          cnt_n    = 16'd0;
        end
      end
      default: begin
        unique case (mstate)
          M_CW: begin
            if (cnt == DP) begin
              mstate_n = M_DEAD_A;
              cnt_n    = 16'd1;
            end else cnt_n = cnt + 16'd1;
          end
          M_DEAD_A: begin
            if (cnt == DT) begin
              mstate_n = M_CCW;
              cnt_n    = 16'd1;
            end else cnt_n = cnt + 16'd1;
          end
          M_CCW: begin
            if (cnt == DP) begin
              mstate_n = M_DEAD_B;
              cnt_n    = 16'd1;
            end else cnt_n = cnt + 16'd1;
          end
          M_DEAD_B: begin
            if (cnt == DT) begin
              mstate_n = M_CW;
              cnt_n    = 16'd1;
            end else cnt_n = cnt + 16'd1;
          end
          M_SPIN: begin
            if (cnt == RS) begin
              cnt_n = 16'd1;
              spd_n = (spd == 4'd15) ? spd : spd + 4'd1;
            end else cnt_n = cnt + 16'd1;
          end
          default: ;
        endcase
      end
    endcase

    en_n     = run & (mstate_n inside {M_CW, M_CCW, M_SPIN});
    dir_n    = mstate_n inside {M_CCW, M_DEAD_B};
    speed_n  = 4'd0;
    if (run && (mstate_n == M_CW || mstate_n == M_CCW)) speed_n = AS;
    if (run && mstate_n == M_SPIN) speed_n = spd_n;
    valve_n  = run & ((stage == 3'd1) || (stage == 3'd3));
    drain_n  = run & ((stage == 3'd4) || (stage == 3'd5));
    buzzer_n = buzz_n != 16'd0;
`ifdef AWMC_DRV_DOOR_LOCK_EN
    dl_cond = (stage != 3'd0) | motor_en;
    dl_n    = dl_cond ? DT : ((dl_cnt != 16'd0) ? dl_cnt - 16'd1 : 16'd0);
    door_n  = dl_cond | fault_n | (dl_cnt != 16'd0);
`endif
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      mstate      <= M_OFF;
      cnt         <= 16'd0;
      spd         <= 4'd0;
      prev_stage  <= 3'd0;
      done_q      <= 1'b0;
      buzz_cnt    <= 16'd0;
      fault       <= 1'b0;
      valve_in    <= 1'b0;
      drain_pump  <= 1'b0;
      motor_en    <= 1'b0;
      motor_dir   <= 1'b0;
      motor_speed <= 4'd0;
      buzzer      <= 1'b0;
`ifdef AWMC_DRV_DOOR_LOCK_EN
      dl_cnt      <= 16'd0;
      door_lock   <= 1'b0;
`endif
    end else begin
      mstate      <= mstate_n;
      cnt         <= cnt_n;
      spd         <= spd_n;
      prev_stage  <= stage;
      done_q      <= done;
      buzz_cnt    <= buzz_n;
      fault       <= fault_n;
      valve_in    <= valve_n;
      drain_pump  <= drain_n;
      motor_en    <= en_n;
      motor_dir   <= dir_n;
      motor_speed <= speed_n;
      buzzer      <= buzzer_n;
`ifdef AWMC_DRV_DOOR_LOCK_EN
      dl_cnt      <= dl_n;
      door_lock   <= door_n;
`endif
    end
  end

endmodule

// File: doc/awmc_actuator_driver.md
# awmc_actuator_driver

Downstream stage of the automatic washing machine controller. It consumes the controller's `stage` code, `done` flag and the user `pause` level, and turns them into registered actuator commands:
- inlet valve and drain pump;
- motor enable, direction and 4-bit speed, covering wash/rinse agitation with dead-time and the spin ramp;
- end-of-cycle buzzer;
- sticky fault on an illegal stage code.

## Interface
Parameters:
- `DIR_PERIOD`, 8: cycles per direction during agitation (≥1).
- `DEAD_TIME`, 2: motor-off cycles between direction reversals (≥1).
- `AGI_SPEED`, 6: motor speed during agitation (1–15).
- `RAMP_STEP`, 4: cycles per +1 speed step during spin (≥1).
- `BUZZ_CYCLES`, 6: buzzer on-time after `done` rises (≥1).

Ports:
- `clk` input 1: single clock, rising edge.
- `reset` input 1: synchronous, active-low; all state is cleared when sampled 0.
- `stage` input 3: controller stage code. 0 IDLE, 1 FILL, 2 WASH, 3 RINSE, 4 DRAIN, 5 SPIN, 6–7 illegal.
- `done` input 1: controller cycle-complete level.
- `pause` input 1: user pause level.
- `valve_in` output 1: inlet valve open.
- `drain_pump` output 1: drain pump on.
- `motor_en` output 1: motor driven.
- `motor_dir` output 1: 0 = CW, 1 = CCW.
- `motor_speed` output 4: speed command.
- `buzzer` output 1: buzzer on.
- `fault` output 1: sticky illegal-stage flag.

## Operation
- All outputs are registered. Each output takes its new value on the clock edge where the driving input is sampled; it is visible from the following cycle.
- `valve_in` = 1 in FILL and RINSE. `drain_pump` = 1 in DRAIN and SPIN. Both are gated off by `pause`, `done` and `fault`.
- **Motor FSM states:** M_OFF, M_CW, M_DEAD_A, M_CCW, M_DEAD_B, M_SPIN.
- **Stage mapping:**
  - IDLE, FILL and DRAIN map to M_OFF: `motor_en`=0, `motor_speed`=0, `motor_dir`=0.
  - WASH and RINSE run agitation.
  - SPIN runs M_SPIN.
- **Agitation sequence:**
  - M_CW (en=1, dir=0, speed=`AGI_SPEED`) for `DIR_PERIOD` cycles.
  - Then M_DEAD_A (en=0, speed=0, dir held) for `DEAD_TIME` cycles.
  - Then M_CCW (en=1, dir=1) for `DIR_PERIOD` cycles.
  - Then M_DEAD_B for `DEAD_TIME` cycles, then back to M_CW. This repeats while the stage holds.
- **Spin:** en=1, dir=0. Speed is 1 on the first cycle, increments by 1 every `RAMP_STEP` cycles and saturates at 15 (no wrap).
- **Stage change:** any change of `stage` aborts the current motor state and the phase counter. The new stage's mode starts from its first state: M_CW with a fresh count, or spin at speed 1.
- **Pause** (level):
  - All actuators are off.
  - The agitation state and its cycle count freeze and resume exactly where they stopped.
  - In spin, speed drops to 0 and the ramp restarts at 1 on resume.
- **`done` = 1:** forces all actuators off and the motor FSM to M_OFF.
- **Buzzer:**
  - A 0→1 edge on `done` loads the buzzer counter with `BUZZ_CYCLES`. `buzzer` is 1 while the counter is non-zero.
  - A new rising edge while the buzzer is active reloads the counter.
  - The buzzer ignores `pause` and `fault`.
- **Fault:** stage 6 or 7 sets `fault`. It stays set until reset and holds all actuators off regardless of later stage values.
- **Priority:** reset > fault > done > pause > stage.

## Timing
- **Reset:** when `reset` is sampled 0, all outputs, counters and the FSM are cleared from the next cycle. That means `fault`=0, `buzzer`=0, `motor_speed`=0, FSM in M_OFF, `done` edge detector cleared. Reset mid-spin drops speed to 0 in one cycle.
- **Latency:** 1 cycle from a `stage`, `pause` or `done` change to the corresponding output change.
- **Agitation period:** 2×(`DIR_PERIOD`+`DEAD_TIME`) cycles. `motor_dir` never changes while `motor_en`=1.
- **Spin ramp:** speed reaches 15 after 1 + 14×`RAMP_STEP` cycles in SPIN. With defaults this is cycle 57.
- **Simultaneous `done` edge and stage change:** `done` wins for actuators, and the buzzer still loads.

## Configuration
- `AWMC_DRV_DOOR_LOCK_EN` defined:
  - Adds an output `door_lock` (1 bit, reset 0).
  - `door_lock` = 1 whenever `stage` ≠ IDLE or `motor_en` = 1.
  - After both conditions clear, it stays 1 for a further `DEAD_TIME` cycles, then drops.
  - A fault keeps `door_lock` = 1 until reset.
- Undefined: the `door_lock` port and its logic are absent. All other behaviour is identical.

## Test plan
- **Reset and FILL:** reset low 2 cycles, then stage=1 → all outputs 0 during reset; one cycle after stage=1, `valve_in`=1 and motor off.
- **Wash, defaults:** stage=2 for 40 cycles → CW 8 cycles, off 2, CCW 8, off 2, CW again; dir never toggles while en=1.
- **Pause in wash:** pause for 5 cycles at cycle 4 of CCW → actuators 0 during the pause; CCW then runs its remaining 4 cycles.
- **Spin:** stage=5 for 70 cycles → speed goes 1, 2, … every 4 cycles and reaches 15 at cycle 57, then holds; pause for 3 cycles → speed 0, then restarts at 1.
- **Done and buzzer:** `done` 0→1 during spin → motor off next cycle, buzzer high 6 cycles; a second edge at buzzer cycle 3 extends it to 9 total.
- **Fault:** stage=7 for 1 cycle, then stage=2 → `fault`=1 and actuators stay off until reset low; with the macro defined, `door_lock` stays 1 until reset.
